// File: rtl/issue_scoreboard_pkg.sv
// Shared types and sizing for the issue scoreboard slice.
package issue_pkg;
  localparam int unsigned NUM_REGS     = 32;
  localparam int unsigned MAX_INFLIGHT = 4;
  localparam int unsigned REG_ADDR_W   = 5;
  localparam int unsigned INFLIGHT_W   = $clog2(MAX_INFLIGHT + 1);

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [INFLIGHT_W-1:0] inflight_t;

  typedef enum logic {
    SB_RUN,
    SB_DRAIN
  } sb_state_e;
endpackage

// File: rtl/issue_scoreboard_if.sv
// Decode/execute/writeback handshake bundle for the issue scoreboard.
// master: decode/execute/writeback side driving requests and retirements.
// slave : the scoreboard, returning issue/stall decisions and status.
interface issue_scoreboard_if;
  import issue_pkg::*;

  logic                i_dec_valid;
  reg_addr_t           i_rs1_addr;
  reg_addr_t           i_rs2_addr;
  reg_addr_t           i_rd_addr;
  logic                i_rs1_used;
  logic                i_rs2_used;
  logic                i_rd_wren;
  logic                i_serialize;
  logic                i_ex_ready;
  logic                i_flush;
  logic                i_wb_valid;
  reg_addr_t           i_wb_addr;
  logic                o_issue;
  logic                o_stall;
  logic [NUM_REGS-1:0] o_busy;
  inflight_t           o_inflight;
  logic                o_err;

  modport master (
    output i_dec_valid, i_rs1_addr, i_rs2_addr, i_rd_addr, i_rs1_used,
           i_rs2_used, i_rd_wren, i_serialize, i_ex_ready, i_flush,
           i_wb_valid, i_wb_addr,
    input  o_issue, o_stall, o_busy, o_inflight, o_err
  );

  modport slave (
    input  i_dec_valid, i_rs1_addr, i_rs2_addr, i_rd_addr, i_rs1_used,
           i_rs2_used, i_rd_wren, i_serialize, i_ex_ready, i_flush,
           i_wb_valid, i_wb_addr,
    output o_issue, o_stall, o_busy, o_inflight, o_err
  );
endinterface

// File: rtl/issue_scoreboard_busy_table.sv
// Per-register pending-write flags. One set port, one clear port; set wins
// when both target the same register. x0 is constant zero.
// Ports: clk/rst_n, set_en/set_addr, clr_en/clr_addr, busy (NUM_REGS flags).
module busy_table
  import issue_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                set_en,
  input  reg_addr_t           set_addr,
  input  logic                clr_en,
  input  reg_addr_t           clr_addr,
  output logic [NUM_REGS-1:0] busy
);

  logic [NUM_REGS-1:1] busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      for (int unsigned r = 1; r < NUM_REGS; r++) begin
        if (set_en && set_addr == REG_ADDR_W'(r)) begin
          busy_q[r] <= 1'b1;
        end else if (clr_en && clr_addr == REG_ADDR_W'(r)) begin
          busy_q[r] <= 1'b0;
        end
      end
    end
  end

  assign busy = {busy_q, 1'b0};

endmodule

// File: rtl/issue_scoreboard.sv
// In-order issue controller: RAW/WAW hazard stall against a busy table,
// writer-count capacity limit, and a drain mode for serializing instructions.
// Ports: i_clk, i_rst (async active-low), bus (issue_scoreboard_if.slave).
// o_issue/o_stall are combinational; table, count, state and o_err are flops.
module issue_scoreboard
  import issue_pkg::*;
#(
  parameter bit BYPASS_WB = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  issue_scoreboard_if.slave  bus
);

  sb_state_e           state;
  inflight_t           inflight;
  logic                err;
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] bypass_mask;
  logic [NUM_REGS-1:0] busy_eff;
  logic                wb_hit;
  logic                wb_ok;
  logic                writer;
  logic                raw;
  logic                waw;
  logic                full;
  logic                mode_ok;
  logic                can_go;
  logic                issue_c;
  logic                stall_c;
  logic                inc;
  logic                dec;

  // Hazard evaluation and issue decision
  always_comb begin
    wb_hit      = bus.i_wb_valid && (bus.i_wb_addr != '0);
    wb_ok       = wb_hit && busy[bus.i_wb_addr];
    bypass_mask = (BYPASS_WB && bus.i_wb_valid) ? (NUM_REGS'(1) << bus.i_wb_addr) : '0;
    busy_eff    = busy & ~bypass_mask;
    writer      = bus.i_rd_wren && (bus.i_rd_addr != '0);
    raw         = (bus.i_rs1_used && busy_eff[bus.i_rs1_addr]) ||
                  (bus.i_rs2_used && busy_eff[bus.i_rs2_addr]);
    waw         = writer && busy_eff[bus.i_rd_addr];
    full        = writer && (inflight == INFLIGHT_W'(MAX_INFLIGHT)) && !bus.i_wb_valid;
    mode_ok     = (state == SB_RUN) ? !bus.i_serialize : (inflight == '0);
    can_go      = bus.i_dec_valid && !bus.i_flush && !raw && !waw && !full && mode_ok;
    // Reset forces both handshake outputs low even though they are combinational.
    issue_c     = can_go && bus.i_ex_ready && i_rst;
    stall_c     = bus.i_dec_valid && !bus.i_flush && !issue_c && i_rst;
    inc         = issue_c && writer;
    // Only a retirement that matches a pending write counts against inflight.
    dec         = wb_ok;
  end

  busy_table u_busy_table (
    .clk      (i_clk),
    .rst_n    (i_rst),
    .set_en   (inc),
    .set_addr (bus.i_rd_addr),
    .clr_en   (wb_hit),
    .clr_addr (bus.i_wb_addr),
    .busy     (busy)
  );

  // Drain FSM, writer counter and sticky error
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state    <= SB_RUN;
      inflight <= '0;
      err      <= 1'b0;
    end else begin
      case (state)
        SB_RUN: begin
          if (bus.i_dec_valid && bus.i_serialize && !bus.i_flush) begin
            state <= SB_DRAIN;
          end
        end
        SB_DRAIN: begin
          if (bus.i_flush || issue_c) begin
            state <= SB_RUN;
          end
        end
        default: state <= SB_RUN;
      endcase

      if (inc && !dec) begin
        inflight <= inflight + INFLIGHT_W'(1);
      end else if (dec && !inc) begin
        inflight <= inflight - INFLIGHT_W'(1);
      end

      if ((wb_hit && !wb_ok) || (dec && !inc && inflight == '0)) begin
        err <= 1'b1;
      end
    end
  end

  assign bus.o_issue    = issue_c;
  assign bus.o_stall    = stall_c;
  assign bus.o_busy     = busy;
  assign bus.o_inflight = inflight;
  assign bus.o_err      = err;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed table-driven bench for issue_scoreboard.
module tb_issue_scoreboard;
  import issue_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  issue_scoreboard_if sb_if ();

  issue_scoreboard #(.BYPASS_WB(1'b1)) dut (
    .i_clk (clk),
    .i_rst (rst_n),
    .bus   (sb_if.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        dv;
    logic [4:0]  rs1;
    logic        u1;
    logic [4:0]  rs2;
    logic        u2;
    logic [4:0]  rd;
    logic        wr;
    logic        ser;
    logic        rdy;
    logic        fl;
    logic        wbv;
    logic [4:0]  wba;
    logic        e_iss;
    logic        e_stl;
    logic [31:0] e_busy;
    logic [2:0]  e_inf;
    logic        e_err;
  } vec_t;

  function automatic logic [31:0] b(input int a);
    return 32'h1 << a;
  endfunction

  function automatic vec_t mk(
    input logic dv, input int rs1, input logic u1, input int rs2, input logic u2,
    input int rd, input logic wr, input logic ser, input logic rdy, input logic fl,
    input logic wbv, input int wba,
    input logic iss, input logic stl, input logic [31:0] bz, input int inf, input logic er);
    vec_t v;
    v.dv = dv; v.rs1 = 5'(rs1); v.u1 = u1; v.rs2 = 5'(rs2); v.u2 = u2;
    v.rd = 5'(rd); v.wr = wr; v.ser = ser; v.rdy = rdy; v.fl = fl;
    v.wbv = wbv; v.wba = 5'(wba);
    v.e_iss = iss; v.e_stl = stl; v.e_busy = bz; v.e_inf = 3'(inf); v.e_err = er;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    sb_if.i_dec_valid = v.dv;
    sb_if.i_rs1_addr  = v.rs1;
    sb_if.i_rs1_used  = v.u1;
    sb_if.i_rs2_addr  = v.rs2;
    sb_if.i_rs2_used  = v.u2;
    sb_if.i_rd_addr   = v.rd;
    sb_if.i_rd_wren   = v.wr;
    sb_if.i_serialize = v.ser;
    sb_if.i_ex_ready  = v.rdy;
    sb_if.i_flush     = v.fl;
    sb_if.i_wb_valid  = v.wbv;
    sb_if.i_wb_addr   = v.wba;
  endtask

  // Drive at falling edge, check decision before rising edge, state after it.
  task automatic apply(input string tag, input vec_t v);
    @(negedge clk);
    drive(v);
    #1;
    chk({tag, ".issue"}, 32'(sb_if.o_issue), 32'(v.e_iss));
    chk({tag, ".stall"}, 32'(sb_if.o_stall), 32'(v.e_stl));
    @(posedge clk);
    #1;
    chk({tag, ".busy"},     sb_if.o_busy,            v.e_busy);
    chk({tag, ".inflight"}, 32'(sb_if.o_inflight),   32'(v.e_inf));
    chk({tag, ".err"},      32'(sb_if.o_err),        32'(v.e_err));
  endtask

  vec_t vt[$];
  vec_t idle;

  initial begin
    idle = mk(0,0,0,0,0,0,0,0,1,0,0,0, 0,0,32'h0,0,0);
    drive(idle);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.issue",    32'(sb_if.o_issue),    32'h0);
    chk("rst.stall",    32'(sb_if.o_stall),    32'h0);
    chk("rst.busy",     sb_if.o_busy,          32'h0);
    chk("rst.inflight", 32'(sb_if.o_inflight), 32'h0);
    chk("rst.err",      32'(sb_if.o_err),      32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    //        dv rs1 u1 rs2 u2 rd wr ser rdy fl wbv wba  iss stl busy            inf err
    // back-to-back RAW on x5, resolved by same-cycle writeback
    vt.push_back(mk(1, 0,0, 0,0, 5,1, 0,1,0, 0,0,  1,0, b(5),              1,0));
    vt.push_back(mk(1, 5,1, 0,0, 6,1, 0,1,0, 0,0,  0,1, b(5),              1,0));
    vt.push_back(mk(1, 0,0, 5,1, 6,1, 0,1,0, 0,0,  0,1, b(5),              1,0));
    vt.push_back(mk(1, 5,1, 0,0, 6,1, 0,1,0, 1,5,  1,0, b(6),              1,0));
    // WAW on x7; set beats clear in the same cycle
    vt.push_back(mk(1, 0,0, 0,0, 7,1, 0,1,0, 0,0,  1,0, b(6)|b(7),         2,0));
    vt.push_back(mk(1, 0,0, 0,0, 7,1, 0,1,0, 0,0,  0,1, b(6)|b(7),         2,0));
    vt.push_back(mk(1, 0,0, 0,0, 7,1, 0,1,0, 1,7,  1,0, b(6)|b(7),         2,0));
    // x0 never busy, no count change
    vt.push_back(mk(1, 0,1, 0,1, 0,1, 0,1,0, 0,0,  1,0, b(6)|b(7),         2,0));
    vt.push_back(mk(0, 0,0, 0,0, 0,0, 0,1,0, 1,6,  0,0, b(7),              1,0));
    // capacity
    vt.push_back(mk(1, 0,0, 0,0, 1,1, 0,1,0, 0,0,  1,0, b(1)|b(7),         2,0));
    vt.push_back(mk(1, 0,0, 0,0, 2,1, 0,1,0, 0,0,  1,0, b(1)|b(2)|b(7),    3,0));
    vt.push_back(mk(1, 0,0, 0,0, 3,1, 0,1,0, 0,0,  1,0, b(1)|b(2)|b(3)|b(7), 4,0));
    vt.push_back(mk(1, 0,0, 0,0, 4,1, 0,1,0, 0,0,  0,1, b(1)|b(2)|b(3)|b(7), 4,0));
    vt.push_back(mk(1, 0,0, 0,0, 4,1, 0,1,0, 1,1,  1,0, b(2)|b(3)|b(4)|b(7), 4,0));
    // execute not ready, then flush
    vt.push_back(mk(1, 0,0, 0,0, 8,1, 0,0,0, 0,0,  0,1, b(2)|b(3)|b(4)|b(7), 4,0));
    vt.push_back(mk(1, 0,0, 0,0, 8,1, 0,1,1, 0,0,  0,0, b(2)|b(3)|b(4)|b(7), 4,0));
    vt.push_back(mk(0, 0,0, 0,0, 0,0, 0,1,0, 1,2,  0,0, b(3)|b(4)|b(7),    3,0));
    vt.push_back(mk(0, 0,0, 0,0, 0,0, 0,1,0, 1,3,  0,0, b(4)|b(7),         2,0));
    // serialize with 2 in flight: drain, then issue at zero
    vt.push_back(mk(1, 0,0, 0,0, 0,0, 1,1,0, 0,0,  0,1, b(4)|b(7),         2,0));
    vt.push_back(mk(1, 0,0, 0,0, 0,0, 1,1,0, 0,0,  0,1, b(4)|b(7),         2,0));
    vt.push_back(mk(1, 0,0, 0,0, 0,0, 1,1,0, 1,4,  0,1, b(7),              1,0));
    vt.push_back(mk(1, 0,0, 0,0, 0,0, 1,1,0, 1,7,  0,1, 32'h0,             0,0));
    vt.push_back(mk(1, 0,0, 0,0, 0,0, 1,1,0, 0,0,  1,0, 32'h0,             0,0));
    // back in RUN: a plain instruction issues despite inflight != 0
    vt.push_back(mk(1, 0,0, 0,0,10,1, 0,1,0, 0,0,  1,0, b(10),             1,0));
    vt.push_back(mk(1, 0,0, 0,0, 0,0, 0,1,0, 0,0,  1,0, b(10),             1,0));
    // flush during drain returns to RUN without issue
    vt.push_back(mk(1, 0,0, 0,0, 0,0, 1,1,0, 0,0,  0,1, b(10),             1,0));
    vt.push_back(mk(1, 0,0, 0,0, 0,0, 1,1,1, 0,0,  0,0, b(10),             1,0));
    vt.push_back(mk(1, 0,0, 0,0, 0,0, 0,1,0, 0,0,  1,0, b(10),             1,0));
    vt.push_back(mk(0, 0,0, 0,0, 0,0, 0,1,0, 1,10, 0,0, 32'h0,             0,0));
    // writeback to non-busy register: sticky error; x0 writeback ignored
    vt.push_back(mk(0, 0,0, 0,0, 0,0, 0,1,0, 1,9,  0,0, 32'h0,             0,1));
    vt.push_back(mk(0, 0,0, 0,0, 0,0, 0,1,0, 0,0,  0,0, 32'h0,             0,1));
    vt.push_back(mk(0, 0,0, 0,0, 0,0, 0,1,0, 1,0,  0,0, 32'h0,             0,1));

    foreach (vt[i]) apply($sformatf("v%0d", i), vt[i]);

    // Reset in the middle of a drain
    apply("pre_rst_w", mk(1,0,0,0,0,12,1,0,1,0,0,0, 1,0,b(12),1,1));
    apply("pre_rst_f", mk(1,0,0,0,0, 0,0,1,1,0,0,0, 0,1,b(12),1,1));
    @(negedge clk);
    drive(mk(1,0,0,0,0,13,1,1,1,0,0,0, 0,0,32'h0,0,0));
    rst_n = 1'b0;
    #1;
    chk("mid_rst.issue",    32'(sb_if.o_issue),    32'h0);
    chk("mid_rst.stall",    32'(sb_if.o_stall),    32'h0);
    @(posedge clk);
    #1;
    chk("mid_rst.busy",     sb_if.o_busy,          32'h0);
    chk("mid_rst.inflight", 32'(sb_if.o_inflight), 32'h0);
    chk("mid_rst.err",      32'(sb_if.o_err),      32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    // Drain tracking discarded: plain instruction issues immediately
    apply("post_rst", mk(1,0,0,0,0,0,0,0,1,0,0,0, 1,0,32'h0,0,0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/issue_scoreboard.md
# issue_scoreboard

In-order issue controller between the decode stage and execute. It keeps a per-register pending-write busy table and stalls decode on RAW and WAW hazards against in-flight results. It also drains the pipeline for serializing instructions and emits the issue handshake that advances decode into execute. Busy bits are set when a writing instruction issues and cleared when its result retires at writeback into the register file.

## Interface
- NUM_REGS, 32: architectural registers; x0 is never busy
- MAX_INFLIGHT, 4: maximum outstanding register-writing instructions
- BYPASS_WB, 1: a same-cycle writeback to a source or destination register resolves the hazard
- i_clk  in  1  clock, all state on rising edge
- i_rst  in  1  reset, asynchronous, active-low
- i_dec_valid  in  1  decode holds a valid instruction
- i_rs1_addr, i_rs2_addr, i_rd_addr  in  5 each  operand and destination fields from decode
- i_rs1_used, i_rs2_used  in  1 each  instruction reads that source
- i_rd_wren  in  1  instruction writes rd
- i_serialize  in  1  instruction must issue into an empty pipeline (fence/CSR)
- i_ex_ready  in  1  execute accepts an instruction this cycle
- i_flush  in  1  kill the decode-stage instruction this cycle (redirect)
- i_wb_valid  in  1  a result retires this cycle
- i_wb_addr  in  5  retiring destination
- o_issue  out  1  instruction transfers decode→execute this cycle
- o_stall  out  1  hold decode and fetch
- o_busy  out  NUM_REGS  busy table
- o_inflight  out  $clog2(MAX_INFLIGHT+1)  outstanding writers
- o_err  out  1  sticky: writeback to a non-busy register, or inflight underflow

## Operation
- busy_eff[r] = busy[r] & ~(BYPASS_WB & i_wb_valid & i_wb_addr==r). busy_eff[0] = 0.
- raw = (i_rs1_used & busy_eff[rs1]) | (i_rs2_used & busy_eff[rs2]).
- waw = i_rd_wren & rd!=0 & busy_eff[rd].
- writer = i_rd_wren & rd!=0.
- full = writer & (o_inflight == MAX_INFLIGHT) & ~i_wb_valid.
- FSM states:
  - RUN: if i_dec_valid & i_serialize & ~i_flush, go to DRAIN without issuing.
  - DRAIN: issue only when o_inflight==0, then return to RUN.
  - i_flush in DRAIN returns to RUN with no issue.
- can_go = i_dec_valid & ~i_flush & ~raw & ~waw & ~full & (state==RUN ? ~i_serialize : o_inflight==0).
- o_issue = can_go & i_ex_ready.
- o_stall = i_dec_valid & ~i_flush & ~o_issue.
- On o_issue & writer: set busy[rd].
- On i_wb_valid & i_wb_addr!=0: clear busy[wb_addr].
- Same register set and cleared in one cycle: final value busy=1.
- o_inflight: +1 on o_issue&writer, −1 on i_wb_valid&wb_addr!=0; both in one cycle leaves it unchanged.
- Writeback to a non-busy register: table unchanged, o_inflight not decremented, o_err set.
- Writebacks to x0 are ignored entirely.

## Timing
- o_issue and o_stall are combinational from current state and inputs; zero-cycle decision.
- Busy table, o_inflight, state and o_err update on the rising edge after the event.
- A dependent instruction issues in the same cycle as the producer's writeback when BYPASS_WB=1, otherwise one cycle later.
- A serializing instruction issues no earlier than one cycle after it is first presented.
- Reset (i_rst=0): busy=0, o_inflight=0, state=RUN, o_err=0; o_issue=0 and o_stall=0 while asserted.
- Reset mid-drain discards all in-flight tracking.

## Structure
- Package issue_pkg holds:
  - the state enum sb_state_e {SB_RUN, SB_DRAIN};
  - REG_ADDR_W=5;
  - the inflight count typedef.
- Sub-module busy_table: NUM_REGS flops with one set port and one clear port, set winning, x0 hard-wired to 0.
- Hazard logic, counter and FSM stay in issue_scoreboard.

## Test plan
- Back-to-back dependency: issue write x5, next instruction reads x5 → o_stall=1 until i_wb_valid with addr 5. With BYPASS_WB=1, o_issue fires in the writeback cycle.
- WAW: two writers to x7 → the second stalls; o_busy[7] stays 1 through a same-cycle wb-clear and issue-set.
- x0: write x0, then read x0 → no stall, o_busy[0]=0, o_inflight unchanged.
- Capacity: 4 writers issued with no writeback → the 5th writer stalls with o_inflight=4. A writeback in the same cycle lets it issue with o_inflight staying at 4.
- Serialize: fence with 2 in flight → DRAIN and stall. Issues the cycle o_inflight==0, then back to RUN. i_flush during DRAIN → RUN with no issue.
- Error and reset: writeback to non-busy x9 → o_err=1 and sticky. Assert i_rst mid-operation → all outputs zero on the next cycle.
